raizing_snd_rom_arb: RTL and testbench
======================================

# raizing_snd_rom_arb

Arbiter sharing one SDRAM read port between the sound Z80 program-ROM fetch path and the OKI M6295 PCM fetch path in the Raizing sound subsystem. Each requester keeps its existing cs/addr/ok/data handshake and gets a one-entry read cache. The arbiter serialises misses onto the single SDRAM slot with round-robin priority. It sits between the sound board (Z80 + NMK112-banked jt6295) and the SDRAM controller.

## Interface
Parameters:
- AW, 22, SDRAM word-address width
- Z80_BASE, 22'h00_0000, SDRAM offset of Z80 program region
- PCM_BASE, 22'h02_0000, SDRAM offset of PCM region

Ports:
- CLK96  in  1  clock; single clock domain
- RESET96  in  1  synchronous, active-high reset
- Z80_CS  in  1  Z80 ROM read request (level)
- Z80_ADDR  in  17  Z80 ROM byte address (banked)
- Z80_OK  out  1  Z80_DOUT valid for current Z80_ADDR
- Z80_DOUT  out  8  Z80 ROM data
- PCM_CS  in  1  PCM read request (level)
- PCM_ADDR  in  20  PCM byte address (post-NMK112)
- PCM_OK  out  1  PCM_DOUT valid for current PCM_ADDR
- PCM_DOUT  out  8  PCM data
- SDRAM_CS  out  1  request to SDRAM controller
- SDRAM_ADDR  out  AW  SDRAM address
- SDRAM_OK  in  1  SDRAM data valid, one-cycle pulse
- SDRAM_DATA  in  8  SDRAM read data
- BUSY  out  1  transaction in flight (debug)

## Operation
- Per requester: cache = {valid, tag (17/20 b), data (8 b)}.
- hit_x = x_CS && valid_x && tag_x == x_ADDR; X_OK = hit_x (combinational from registered cache); X_DOUT = data_x, always driven.
- miss_x = x_CS && !hit_x.
- FSM states: IDLE, SERVE_Z80, SERVE_PCM.
  - IDLE: if only one miss, grant it. If both miss, grant the requester not served last (`last` register; reset value = PCM, so Z80 wins the first tie). Latch the requester address into `req_addr`; go to SERVE_x.
  - SERVE_x: SDRAM_CS=1, SDRAM_ADDR=x_BASE + zero-extended `req_addr`, both held constant. On SDRAM_OK: tag_x<=req_addr, data_x<=SDRAM_DATA, valid_x<=1, last<=x, go to IDLE.
- Requester changes address or drops CS mid-transaction: the transaction still completes and fills the cache with the latched address; no abort. The new address then misses and re-arbitrates.
- Address wrap: base + address is computed at AW bits and truncated; no overflow flag.
- SDRAM_OK in IDLE is ignored.
- Reset (including mid-transaction): state=IDLE, SDRAM_CS=0, SDRAM_ADDR=0, valid_z80=valid_pcm=0, tags/data=0, last=PCM, BUSY=0. Consequently Z80_OK=PCM_OK=0 and Z80_DOUT=PCM_DOUT=0.

## Timing
- Hit: X_OK in the same cycle the address is presented (0 latency).
- Miss: the miss is seen in IDLE at cycle 0. SDRAM_CS rises at cycle 1. SDRAM_OK arrives at cycle N ≥ 1 with data. Cache is written at the N edge, so X_OK is high from cycle N+1.
- Back-to-back: IDLE is entered for exactly one cycle between transactions, so a second pending miss starts SDRAM_CS at N+2.
- SDRAM_CS deasserts the cycle after SDRAM_OK (registered), never earlier.
- BUSY = (state != IDLE), registered.
- Worst-case Z80 wait = one full PCM transaction plus its own.

## Structure
- Shared package `raizing_snd_pkg` holds:
  - state enum (IDLE/SERVE_Z80/SERVE_PCM)
  - requester id constants (REQ_Z80=0, REQ_PCM=1)
  - default base constants
- Natural sub-module: `raizing_rom_cache1`, a single-entry tag/data/valid register with hit compare and fill port, instantiated twice (tag width parameter 17/20).
- FSM and round-robin logic live in the top.

## Test plan
- Z80 miss, addr 17'h01234, SDRAM latency 3 → SDRAM_ADDR=22'h001234 at cycle 1; Z80_OK at cycle 4 with data 8'hA5; same addr again → Z80_OK same cycle, no SDRAM_CS.
- PCM miss, addr 20'h4_0010 → SDRAM_ADDR=22'h060010; PCM_DOUT matches returned byte.
- Simultaneous Z80 and PCM misses after reset → Z80 served first, PCM second. Repeat with fresh addresses → PCM served first (round-robin).
- Z80_ADDR changes 0x100→0x101 while SERVE_Z80 is pending → cache tag becomes 0x100, Z80_OK stays low, new transaction for 0x101 follows.
- RESET96 pulsed while SDRAM_CS=1 → next cycle SDRAM_CS=0, both OK=0; a late SDRAM_OK is ignored; previously cached addresses miss again.
- Random mix of 10k requests with random SDRAM latency 1–8 → every OK'd byte matches the reference memory model; SDRAM_ADDR stable whenever SDRAM_CS is high.

Source files
------------

// File: rtl/raizing_snd_pkg.sv
// Shared constants for the Raizing sound ROM arbiter.
// Holds the FSM state codes, requester ids, widths and default SDRAM bases.
package raizing_snd_pkg;

    localparam int unsigned SDRAM_AW = 22;
    localparam int unsigned Z80_AW   = 17;
    localparam int unsigned PCM_AW   = 20;
    localparam int unsigned DW       = 8;
    localparam int unsigned STATE_W  = 2;

    // Arbiter states
    localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ST_SERVE_Z80 = 2'd1;
    localparam logic [STATE_W-1:0] ST_SERVE_PCM = 2'd2;

    // Requester ids, used by the round-robin `last` register
    localparam logic REQ_Z80 = 1'b0;
    localparam logic REQ_PCM = 1'b1;

    // Default SDRAM word offsets of each region
    localparam logic [SDRAM_AW-1:0] Z80_BASE_DEF = 22'h00_0000;
    localparam logic [SDRAM_AW-1:0] PCM_BASE_DEF = 22'h02_0000;

endpackage

// File: rtl/raizing_rom_cache1.sv
// Single-entry read cache: valid/tag/data register with hit compare and fill port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cs, addr        requester strobe and address compared against the tag
//   fill            write fill_tag/fill_data and set valid
//   hit_c           combinational hit (cs && valid && tag == addr)
//   data            registered cached byte, always driven
module raizing_rom_cache1
    import raizing_snd_pkg::*;
#(
    parameter int unsigned TW = Z80_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [TW-1:0] addr,
    input  logic          fill,
    input  logic [TW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    output logic          hit_c,
    output logic [DW-1:0] data
);

    logic          valid;
    logic [TW-1:0] tag;

    // Entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

    assign hit_c = cs && valid && (tag == addr);

endmodule

// File: rtl/raizing_snd_rom_arb.sv
// Shares one SDRAM read port between the Z80 program fetch and the OKI PCM fetch.
// Each requester has a one-entry cache; misses are serialised round-robin.
// Ports:
//   CLK96, RESET96          clock, synchronous active-high reset
//   Z80_CS/ADDR/OK/DOUT     Z80 ROM handshake (OK combinational from cache)
//   PCM_CS/ADDR/OK/DOUT     PCM ROM handshake (OK combinational from cache)
//   SDRAM_CS/ADDR           registered request, held stable until SDRAM_OK
//   SDRAM_OK/DATA           one-cycle data-valid pulse and read byte
//   BUSY                    registered, high while a transaction is in flight
module raizing_snd_rom_arb
    import raizing_snd_pkg::*;
#(
    parameter int unsigned    AW       = SDRAM_AW,
    parameter logic [AW-1:0]  Z80_BASE = AW'(Z80_BASE_DEF),
    parameter logic [AW-1:0]  PCM_BASE = AW'(PCM_BASE_DEF)
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              Z80_CS,
    input  logic [Z80_AW-1:0] Z80_ADDR,
    output logic              Z80_OK,
    output logic [DW-1:0]     Z80_DOUT,
    input  logic              PCM_CS,
    input  logic [PCM_AW-1:0] PCM_ADDR,
    output logic              PCM_OK,
    output logic [DW-1:0]     PCM_DOUT,
    output logic              SDRAM_CS,
    output logic [AW-1:0]     SDRAM_ADDR,
    input  logic              SDRAM_OK,
    input  logic [DW-1:0]     SDRAM_DATA,
    output logic              BUSY
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_d;
    logic [PCM_AW-1:0]  req_addr;
    logic               last;
    logic               start;
    logic               grant_pcm;
    logic               z80_miss;
    logic               pcm_miss;
    logic               z80_fill;
    logic               pcm_fill;

    assign z80_miss = Z80_CS && !Z80_OK;
    assign pcm_miss = PCM_CS && !PCM_OK;
    assign z80_fill = (state == ST_SERVE_Z80) && SDRAM_OK;
    assign pcm_fill = (state == ST_SERVE_PCM) && SDRAM_OK;

    // Z80 program cache; tag is the low part of the shared latched address
    raizing_rom_cache1 #(.TW(Z80_AW)) u_z80_cache (
        .clk       (CLK96),
        .rst       (RESET96),
        .cs        (Z80_CS),
        .addr      (Z80_ADDR),
        .fill      (z80_fill),
        .fill_tag  (req_addr[Z80_AW-1:0]),
        .fill_data (SDRAM_DATA),
        .hit_c     (Z80_OK),
        .data      (Z80_DOUT)
    );

    // PCM sample cache
    raizing_rom_cache1 #(.TW(PCM_AW)) u_pcm_cache (
        .clk       (CLK96),
        .rst       (RESET96),
        .cs        (PCM_CS),
        .addr      (PCM_ADDR),
        .fill      (pcm_fill),
        .fill_tag  (req_addr),
        .fill_data (SDRAM_DATA),
        .hit_c     (PCM_OK),
        .data      (PCM_DOUT)
    );

    // State register
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and grant; a tie goes to whoever was not served last
    always_comb begin
        state_d   = state;
        start     = 1'b0;
        grant_pcm = 1'b0;
        case (state)
            ST_IDLE: begin
                if (z80_miss && pcm_miss) begin
                    start     = 1'b1;
                    grant_pcm = (last == REQ_Z80);
                end else if (z80_miss) begin
                    start     = 1'b1;
                end else if (pcm_miss) begin
                    start     = 1'b1;
                    grant_pcm = 1'b1;
                end
                if (start) begin
                    state_d = grant_pcm ? ST_SERVE_PCM : ST_SERVE_Z80;
                end
            end
            ST_SERVE_Z80,
            ST_SERVE_PCM: begin
                if (SDRAM_OK) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered SDRAM request, latched address and round-robin history.
    // The address is only loaded on grant, so it cannot move while CS is high
    // even if the requester changes its address mid-transaction.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            SDRAM_CS   <= 1'b0;
            SDRAM_ADDR <= '0;
            BUSY       <= 1'b0;
            req_addr   <= '0;
            last       <= REQ_PCM;
        end else begin
            SDRAM_CS <= (state_d != ST_IDLE);
            BUSY     <= (state_d != ST_IDLE);
            if (start) begin
                if (grant_pcm) begin
                    req_addr   <= PCM_ADDR;
                    SDRAM_ADDR <= PCM_BASE + AW'(PCM_ADDR);
                end else begin
                    req_addr   <= PCM_AW'(Z80_ADDR);
                    SDRAM_ADDR <= Z80_BASE + AW'(Z80_ADDR);
                end
            end
            if (z80_fill) begin
                last <= REQ_Z80;
            end
            if (pcm_fill) begin
                last <= REQ_PCM;
            end
        end
    end

endmodule

// File: tb/tb_raizing_snd_rom_arb.sv
// Self-checking bench for raizing_snd_rom_arb: directed scenarios plus a
// randomized run against a behavioural SDRAM/ROM model.
module tb_raizing_snd_rom_arb;

    localparam int unsigned AW = 22;
    localparam logic [AW-1:0] ZB = 22'h00_0000;
    localparam logic [AW-1:0] PB = 22'h02_0000;

    logic        CLK96 = 1'b0;
    logic        RESET96;
    logic        Z80_CS;
    logic [16:0] Z80_ADDR;
    logic        Z80_OK;
    logic [7:0]  Z80_DOUT;
    logic        PCM_CS;
    logic [19:0] PCM_ADDR;
    logic        PCM_OK;
    logic [7:0]  PCM_DOUT;
    logic        SDRAM_CS;
    logic [AW-1:0] SDRAM_ADDR;
    logic        SDRAM_OK;
    logic [7:0]  SDRAM_DATA;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    logic       auto_en = 1'b0;
    int         fixed_lat = 3;
    logic       auto_ok = 1'b0;
    logic [7:0] auto_data = 8'h00;
    logic       man_ok = 1'b0;
    logic [7:0] man_data = 8'h00;

    assign SDRAM_OK   = auto_ok | man_ok;
    assign SDRAM_DATA = man_ok ? man_data : auto_data;

    always #5 CLK96 = ~CLK96;

    raizing_snd_rom_arb dut (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .Z80_CS     (Z80_CS),
        .Z80_ADDR   (Z80_ADDR),
        .Z80_OK     (Z80_OK),
        .Z80_DOUT   (Z80_DOUT),
        .PCM_CS     (PCM_CS),
        .PCM_ADDR   (PCM_ADDR),
        .PCM_OK     (PCM_OK),
        .PCM_DOUT   (PCM_DOUT),
        .SDRAM_CS   (SDRAM_CS),
        .SDRAM_ADDR (SDRAM_ADDR),
        .SDRAM_OK   (SDRAM_OK),
        .SDRAM_DATA (SDRAM_DATA),
        .BUSY       (BUSY)
    );

    // Reference SDRAM contents: one byte per word address
    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        logic [7:0] b;
        if (a == 22'h00_1234) return 8'hA5;
        b = a[7:0] * 8'd37;
        return b ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land at the sampling point
    task automatic cyc();
        @(posedge CLK96);
        #3;
    endtask

    task automatic wait_ok(input logic pcm, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            cyc();
            n++;
            if (pcm ? PCM_OK : Z80_OK) break;
        end
    endtask

    // SDRAM model: answers after a per-transaction latency, checks address hold
    initial begin
        int cnt;
        int lat;
        logic [AW-1:0] cap;
        cnt = 0;
        lat = 1;
        cap = '0;
        forever begin
            @(posedge CLK96);
            #1;
            auto_ok = 1'b0;
            if (!SDRAM_CS) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    cap = SDRAM_ADDR;
                    lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
                end else begin
                    chk("sdram_addr_stable", 32'(SDRAM_ADDR), 32'(cap));
                end
                cnt++;
                if (auto_en && cnt == lat) begin
                    auto_ok   = 1'b1;
                    auto_data = mem_byte(SDRAM_ADDR);
                end
            end
        end
    end

    initial begin
        int n;
        int zwait;
        int pwait;
        RESET96  = 1'b1;
        Z80_CS   = 1'b0;
        Z80_ADDR = '0;
        PCM_CS   = 1'b0;
        PCM_ADDR = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_sdram_cs", 32'(SDRAM_CS), 0);
        chk("rst_sdram_addr", 32'(SDRAM_ADDR), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_z80_ok", 32'(Z80_OK), 0);
        chk("rst_pcm_ok", 32'(PCM_OK), 0);
        chk("rst_z80_dout", 32'(Z80_DOUT), 0);
        chk("rst_pcm_dout", 32'(PCM_DOUT), 0);
        RESET96   = 1'b0;
        auto_en   = 1'b1;
        fixed_lat = 3;
        cyc();

        // Z80 miss, latency 3: CS at cycle 1, SDRAM_OK at 3, Z80_OK at 4
        Z80_CS   = 1'b1;
        Z80_ADDR = 17'h0_1234;
        #1;
        chk("z80_miss_ok_c0", 32'(Z80_OK), 0);
        cyc();
        chk("z80_sdram_cs_c1", 32'(SDRAM_CS), 1);
        chk("z80_sdram_addr_c1", 32'(SDRAM_ADDR), 32'h00_1234);
        chk("z80_busy_c1", 32'(BUSY), 1);
        cyc();
        chk("z80_ok_c2", 32'(Z80_OK), 0);
        cyc();
        chk("z80_sdram_ok_c3", 32'(SDRAM_OK), 1);
        chk("z80_ok_c3", 32'(Z80_OK), 0);
        chk("z80_sdram_cs_c3", 32'(SDRAM_CS), 1);
        cyc();
        chk("z80_ok_c4", 32'(Z80_OK), 1);
        chk("z80_dout_c4", 32'(Z80_DOUT), 32'hA5);
        chk("z80_sdram_cs_c4", 32'(SDRAM_CS), 0);
        chk("z80_busy_c4", 32'(BUSY), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("z80_hit_no_cs", 32'(SDRAM_CS), 0);
            chk("z80_hit_ok", 32'(Z80_OK), 1);
        end

        // PCM miss mapped into the PCM region
        Z80_CS   = 1'b0;
        PCM_CS   = 1'b1;
        PCM_ADDR = 20'h4_0010;
        cyc();
        chk("pcm_sdram_cs", 32'(SDRAM_CS), 1);
        chk("pcm_sdram_addr", 32'(SDRAM_ADDR), 32'h06_0010);
        wait_ok(1'b1, 20, n);
        chk("pcm_ok_seen", 32'(PCM_OK), 1);
        chk("pcm_dout", 32'(PCM_DOUT), 32'(mem_byte(22'h06_0010)));

        // Simultaneous misses straight after reset: Z80 wins the tie
        PCM_CS  = 1'b0;
        RESET96 = 1'b1;
        cyc();
        RESET96   = 1'b0;
        fixed_lat = 0;
        cyc();
        Z80_CS   = 1'b1;
        Z80_ADDR = 17'h0_AAAA;
        PCM_CS   = 1'b1;
        PCM_ADDR = 20'h1_2345;
        cyc();
        chk("tie1_first_z80", 32'(SDRAM_ADDR), 32'(ZB + 22'h0_AAAA));
        wait_ok(1'b0, 20, n);
        chk("tie1_z80_ok", 32'(Z80_OK), 1);
        chk("tie1_pcm_waits", 32'(PCM_OK), 0);
        cyc();
        chk("tie1_second_cs", 32'(SDRAM_CS), 1);
        chk("tie1_second_pcm", 32'(SDRAM_ADDR), 32'(PB + 22'h1_2345));
        wait_ok(1'b1, 20, n);
        chk("tie1_pcm_ok", 32'(PCM_OK), 1);
        chk("tie1_pcm_dout", 32'(PCM_DOUT), 32'(mem_byte(PB + 22'h1_2345)));

        // A lone Z80 fill makes Z80 the last served, so the next tie goes to PCM
        Z80_ADDR = 17'h0_BBBB;
        wait_ok(1'b0, 20, n);
        chk("rr_z80_fill", 32'(Z80_OK), 1);
        Z80_ADDR = 17'h0_CCCC;
        PCM_ADDR = 20'h2_3456;
        cyc();
        chk("tie2_first_pcm", 32'(SDRAM_ADDR), 32'(PB + 22'h2_3456));
        wait_ok(1'b1, 20, n);
        chk("tie2_pcm_ok", 32'(PCM_OK), 1);
        cyc();
        chk("tie2_second_z80", 32'(SDRAM_ADDR), 32'(ZB + 22'h0_CCCC));
        wait_ok(1'b0, 20, n);
        chk("tie2_z80_dout", 32'(Z80_DOUT), 32'(mem_byte(ZB + 22'h0_CCCC)));

        // Address change while the Z80 transaction is pending
        PCM_CS    = 1'b0;
        fixed_lat = 4;
        Z80_ADDR  = 17'h0_0100;
        cyc();
        chk("chg_sdram_addr", 32'(SDRAM_ADDR), 32'h00_0100);
        Z80_ADDR = 17'h0_0101;
        n = 0;
        while (!SDRAM_OK && n < 12) begin
            cyc();
            n++;
            chk("chg_ok_low_pending", 32'(Z80_OK), 0);
        end
        chk("chg_sdram_ok_seen", 32'(SDRAM_OK), 1);
        cyc();
        chk("chg_ok_low_after_fill", 32'(Z80_OK), 0);
        chk("chg_cs_drop", 32'(SDRAM_CS), 0);
        Z80_ADDR = 17'h0_0100;
        #1;
        chk("chg_tag_is_old_addr", 32'(Z80_OK), 1);
        chk("chg_old_data", 32'(Z80_DOUT), 32'(mem_byte(22'h00_0100)));
        Z80_ADDR = 17'h0_0101;
        #1;
        cyc();
        chk("chg_new_cs", 32'(SDRAM_CS), 1);
        chk("chg_new_addr", 32'(SDRAM_ADDR), 32'h00_0101);
        wait_ok(1'b0, 20, n);
        chk("chg_new_dout", 32'(Z80_DOUT), 32'(mem_byte(22'h00_0101)));

        // Reset mid-transaction, then a stray SDRAM_OK in IDLE
        auto_en  = 1'b0;
        Z80_CS   = 1'b0;
        PCM_CS   = 1'b1;
        PCM_ADDR = 20'h3_3333;
        cyc();
        chk("mid_cs_up", 32'(SDRAM_CS), 1);
        cyc();
        RESET96 = 1'b1;
        cyc();
        chk("mid_rst_cs", 32'(SDRAM_CS), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_pcm_ok", 32'(PCM_OK), 0);
        chk("mid_rst_z80_ok", 32'(Z80_OK), 0);
        RESET96  = 1'b0;
        PCM_CS   = 1'b0;
        man_ok   = 1'b1;
        man_data = 8'hEE;
        cyc();
        man_ok = 1'b0;
        cyc();
        chk("late_ok_busy", 32'(BUSY), 0);
        chk("late_ok_cs", 32'(SDRAM_CS), 0);
        chk("late_ok_pcm_dout", 32'(PCM_DOUT), 0);
        chk("late_ok_z80_dout", 32'(Z80_DOUT), 0);
        Z80_CS   = 1'b1;
        Z80_ADDR = 17'h0_0101;
        #1;
        chk("post_rst_miss", 32'(Z80_OK), 0);
        auto_en   = 1'b1;
        fixed_lat = 0;
        cyc();
        chk("post_rst_refetch", 32'(SDRAM_ADDR), 32'h00_0101);
        wait_ok(1'b0, 20, n);
        chk("post_rst_dout", 32'(Z80_DOUT), 32'(mem_byte(22'h00_0101)));

        // Random mix with random latency 1..8
        zwait = 0;
        pwait = 0;
        for (int i = 0; i < 10000; i++) begin
            if (Z80_OK) chk("rnd_z80_data", 32'(Z80_DOUT), 32'(mem_byte(ZB + AW'(Z80_ADDR))));
            if (PCM_OK) chk("rnd_pcm_data", 32'(PCM_DOUT), 32'(mem_byte(PB + AW'(PCM_ADDR))));
            if (!Z80_CS) chk("rnd_z80_ok_no_cs", 32'(Z80_OK), 0);
            if (!PCM_CS) chk("rnd_pcm_ok_no_cs", 32'(PCM_OK), 0);
            zwait = (Z80_CS && !Z80_OK) ? zwait + 1 : 0;
            pwait = (PCM_CS && !PCM_OK) ? pwait + 1 : 0;
            chk("rnd_z80_wait_bound", 32'(zwait > 24), 0);
            chk("rnd_pcm_wait_bound", 32'(pwait > 24), 0);
            if ($urandom_range(0, 5) == 0) begin
                Z80_ADDR = 17'($urandom_range(0, 7)) ^ (($urandom_range(0, 1) != 0) ? 17'h1_FFF8 : 17'h0_0040);
                zwait = 0;
            end
            if ($urandom_range(0, 5) == 0) begin
                PCM_ADDR = 20'($urandom_range(0, 7)) ^ (($urandom_range(0, 1) != 0) ? 20'hF_FFF8 : 20'h0_0100);
                pwait = 0;
            end
            if ($urandom_range(0, 9) == 0) begin
                Z80_CS = ~Z80_CS;
                zwait = 0;
            end
            if ($urandom_range(0, 9) == 0) begin
                PCM_CS = ~PCM_CS;
                pwait = 0;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
